// File: rtl/hayes_pkg.sv
// Shared constants for the complex-plane scan generator: default widths,
// default raster size and the FSM state encoding.
package hayes_pkg;

  localparam int W_DEF     = 16;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/scan_axis_counter.sv
// Wrap counter for one raster axis: counts 0..COUNT-1 on enable, flags the
// terminal count, and can be forced back to zero.
module scan_axis_counter #(
  parameter int COUNT = 4,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/z_scan_gen.sv
// Raster scan of the complex plane: emits z = (x0 + x*step, y0 - y*step) one
// pixel per handshake, using add/subtract accumulators instead of multipliers.
//
// state | meaning
// IDLE  | waiting for start; z_valid=0
// RUN   | presenting samples; advances on z_valid & z_ready
module z_scan_gen
  import hayes_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int W     = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] step,
  output logic         z_valid,
  input  logic         z_ready,
  output logic [W-1:0] z_re,
  output logic [W-1:0] z_im,
  output logic         z_eol,
  output logic         z_last,
  output logic         busy,
  output logic         done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  scan_state_e  state_q, state_d;
  logic [W-1:0] x0_q, x0_d;
  logic [W-1:0] step_q, step_d;
  logic [W-1:0] re_q, re_d;
  logic [W-1:0] im_q, im_d;
  logic         done_q, done_d;
  logic         cnt_clr;
  logic         fire;
  logic         x_tc, y_tc;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;

  // z_valid is a pure decode of the state register, so z_ready never reaches it.
  assign busy    = (state_q == ST_RUN);
  assign z_valid = busy;
  assign fire    = z_valid & z_ready;
  assign z_eol   = busy & x_tc;
  assign z_last  = busy & x_tc & y_tc;
  assign z_re    = re_q;
  assign z_im    = im_q;
  assign done    = done_q;

  scan_axis_counter #(.COUNT(H_RES), .CW(XW)) u_x_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (fire),
    .cnt_o (x_cnt),
    .tc_o  (x_tc)
  );

  scan_axis_counter #(.COUNT(V_RES), .CW(YW)) u_y_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (fire & x_tc),
    .cnt_o (y_cnt),
    .tc_o  (y_tc)
  );

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    step_d  = step_q;
    re_d    = re_q;
    im_d    = im_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          x0_d    = x0;
          step_d  = step;
          re_d    = x0;
          im_d    = y0;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (fire) begin
          if (z_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (x_tc) begin
            re_d = x0_q;
            im_d = im_q - step_q;
          end else begin
            re_d = re_q + step_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      step_q  <= '0;
      re_q    <= '0;
      im_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      step_q  <= step_d;
      re_q    <= re_d;
      im_q    <= im_d;
      done_q  <= done_d;
    end
  end

  // Counter values themselves are only consumed through their terminal flags.
  logic unused_cnt;
  assign unused_cnt = ^{x_cnt, y_cnt};

endmodule

// File: tb/tb_z_scan_gen.sv
// Directed bench for z_scan_gen on a 4x3 raster with hand-derived sample sequences.
module tb_z_scan_gen;

  localparam int H = 4;
  localparam int V = 3;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, z_ready;
  logic [W-1:0] x0, y0, step;
  logic         z_valid, z_eol, z_last, busy, done;
  logic [W-1:0] z_re, z_im;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  z_scan_gen #(.H_RES(H), .V_RES(V), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .x0      (x0),
    .y0      (y0),
    .step    (step),
    .z_valid (z_valid),
    .z_ready (z_ready),
    .z_re    (z_re),
    .z_im    (z_im),
    .z_eol   (z_eol),
    .z_last  (z_last),
    .busy    (busy),
    .done    (done)
  );

  // Drives one frame from the current negedge and checks every presented
  // sample, including repeats while stalled. With do_start=0 the caller has
  // already raised start on this negedge. Stops after n_limit transfers.
  task automatic run_scan(input logic [15:0] sx0, input logic [15:0] sy0,
                          input logic [15:0] sst, input bit do_start,
                          input bit stall, input bit poke, input int n_limit);
    int n, c, xi, yi;
    logic [15:0] er, ei;
    bit r;
    if (do_start) begin
      @(negedge clk);
      x0 = sx0; y0 = sy0; step = sst; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    n = 0;
    c = 0;
    while (n < n_limit && c < 200) begin
      xi = n % H;
      yi = n / H;
      er = sx0 + 16'(xi) * sst;
      ei = sy0 - 16'(yi) * sst;
      tests++;
      if (z_valid !== 1'b1 || z_re !== er || z_im !== ei ||
          z_eol !== (xi == H - 1) || z_last !== (n == H * V - 1) ||
          busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL sample%0d: valid=%b re=%h im=%h eol=%b last=%b busy=%b done=%b, want 1 %h %h %b %b 1 0",
                 n, z_valid, z_re, z_im, z_eol, z_last, busy, done,
                 er, ei, (xi == H - 1), (n == H * V - 1));
      end
      r = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      z_ready = r;
      if (poke && n == 5) begin
        start = 1'b1; x0 = 16'h1234; y0 = 16'h4321; step = 16'h0007;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (r) n++;
      c++;
    end
    start = 1'b0;
    if (n < n_limit) begin
      tests++;
      fails++;
      $display("FAIL scan_budget: got %0d transfers, want %0d", n, n_limit);
    end
    if (n_limit == H * V) begin
      tests++;
      if (z_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
        fails++;
        $display("FAIL done_cycle: valid=%b busy=%b done=%b, want 0 0 1", z_valid, busy, done);
      end
    end
  endtask

  task automatic check_idle_after(input string name);
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || z_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: done=%b valid=%b busy=%b, want 0 0 0", name, done, z_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; z_ready = 1'b0;
    x0 = 16'h5555; y0 = 16'hAAAA; step = 16'h0003;
    repeat (2) @(negedge clk);
    tests++;
    if ({z_valid, z_re, z_im, z_eol, z_last, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_state: valid=%b re=%h im=%h eol=%b last=%b busy=%b done=%b, want all 0",
               z_valid, z_re, z_im, z_eol, z_last, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (z_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: valid=%b busy=%b, want 0 0", z_valid, busy);
    end
  endtask

  task automatic test_basic();
    run_scan(16'hFFFE, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, H * V);
    check_idle_after("basic");
  endtask

  task automatic test_stall();
    run_scan(16'hFFFE, 16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0, H * V);
    check_idle_after("stall");
  endtask

  task automatic test_wrap();
    run_scan(16'h7FFF, 16'h8001, 16'h0001, 1'b1, 1'b0, 1'b0, H * V);
    check_idle_after("wrap");
  endtask

  task automatic test_ignore_start();
    run_scan(16'hFFFE, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1, H * V);
    check_idle_after("ignore_start");
  endtask

  task automatic test_back_to_back();
    run_scan(16'hFFFE, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, H * V);
    x0 = 16'h0010; y0 = 16'h0020; step = 16'h0002; start = 1'b1;
    run_scan(16'h0010, 16'h0020, 16'h0002, 1'b0, 1'b1, 1'b0, H * V);
    check_idle_after("back_to_back");
  endtask

  task automatic test_reset_mid();
    run_scan(16'hFFFE, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 5);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({z_valid, z_re, z_im, z_eol, z_last, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_async: valid=%b re=%h im=%h eol=%b last=%b busy=%b done=%b, want all 0",
               z_valid, z_re, z_im, z_eol, z_last, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || z_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_no_done: cycle %0d done=%b valid=%b, want 0 0", i, done, z_valid);
      end
    end
    run_scan(16'hFFFE, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, H * V);
    check_idle_after("reset_mid");
  endtask

  task automatic test_step_zero();
    run_scan(16'h1234, 16'hABCD, 16'h0000, 1'b1, 1'b1, 1'b0, H * V);
    check_idle_after("step_zero");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_step_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/z_scan_gen.md
Z_SCAN_GEN -- requirements
Module: z_scan_gen

Interface
REQ-001 The module SHALL have parameter H_RES, default 640, pixels per line.
REQ-002 The module SHALL have parameter V_RES, default 480, lines per frame.
REQ-003 The module SHALL have parameter W, default 16, bit width of each complex component, in two's complement.
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a frame scan; sampled only in IDLE.
- x0  in  W  real part of the top-left pixel; latched on start.
- y0  in  W  imaginary part of the top-left pixel; latched on start.
- step  in  W  pixel pitch, unsigned magnitude; latched on start.
- z_valid  out  1  z_re/z_im carry a sample.
- z_ready  in  1  downstream (function evaluator) accepts the sample.
- z_re  out  W  real part of the current sample.
- z_im  out  W  imaginary part of the current sample.
- z_eol  out  1  current sample is the last of its line.
- z_last  out  1  current sample is the last of the frame.
- busy  out  1  a frame scan is in progress.
- done  out  1  single-cycle pulse at frame completion.

Function
REQ-005 States SHALL be IDLE and RUN; the FSM SHALL leave IDLE for RUN on start=1 and return to IDLE on the handshake (z_valid & z_ready) of the z_last sample.
REQ-006 On accepting start at edge N, the block SHALL latch x0, y0 and step, and SHALL present z=(x0,y0) with z_valid=1 from edge N+1.
REQ-007 A transfer SHALL occur only on a cycle where z_valid=1 and z_ready=1.
REQ-008 While z_valid=1 and z_ready=0, z_re, z_im, z_eol and z_last SHALL hold stable.
REQ-009 Throughput SHALL be one sample per cycle while z_ready=1.
REQ-010 Pixel order SHALL be raster: x from 0 to H_RES-1, then y from 0 to V_RES-1.
REQ-011 Sample (x,y) SHALL equal z_re = x0 + x*step and z_im = y0 - y*step, computed by accumulators (add or subtract step per transfer), with no multiplier.
REQ-012 After an eol transfer, z_re SHALL reload the latched x0 and z_im SHALL decrement by step.
REQ-013 All arithmetic SHALL wrap modulo 2^W, with no saturation; 0x7FFF+1 = 0x8000.
REQ-014 z_eol SHALL be 1 exactly when x = H_RES-1, and z_last SHALL be 1 exactly when x = H_RES-1 and y = V_RES-1.
REQ-015 busy SHALL be 1 from edge N+1 through the edge of the last transfer, exclusive.
REQ-016 On the edge after the last transfer, the block SHALL have z_valid=0, busy=0 and done=1 for one cycle.
REQ-017 start SHALL be ignored while busy=1; input changes to x0, y0 and step during RUN SHALL have no effect.
REQ-018 start=1 during the done cycle SHALL be accepted (IDLE), giving back-to-back frames with a one-cycle bubble.
REQ-019 step=0 SHALL be legal and SHALL produce H_RES*V_RES samples all equal to (x0,y0).
REQ-020 The block SHALL contain no combinational path from z_ready to z_valid; z_valid SHALL be registered.

Reset
REQ-021 On rst=1, asynchronously, the FSM SHALL be IDLE and z_valid, z_re, z_im, z_eol, z_last, busy and done SHALL all be 0.
REQ-022 On rst=1, counters and latched configuration SHALL be 0.
REQ-023 Reset mid-frame SHALL abort the scan with no done pulse; the next start SHALL restart at (x0,y0) with x=y=0.

Structure
REQ-024 Shared package hayes_pkg SHALL hold W, the default H_RES and V_RES, and the FSM state encoding constants.
REQ-025 Counter widths SHALL be $clog2(H_RES) and $clog2(V_RES), derived locally.
REQ-026 One sub-module, scan_axis_counter, SHALL implement a wrap counter with enable, terminal-count flag and load-to-zero, instantiated once for x and once for y.
REQ-027 Outputs SHALL connect directly to func_eval z_re/z_im; downstream pipelining is out of scope.

Verification
REQ-028 H_RES=4, V_RES=3, x0=0xFFFE, y0=0x0001, step=1, z_ready=1 -> re sequence FFFE,FFFF,0000,0001 per line; im 0001,0000,FFFF; eol on samples 4/8/12; last on 12; done on the next cycle.
REQ-029 Same setup with z_ready toggling 1,0,0,1 repeating -> 12 transfers in identical order; outputs stable through every stall.
REQ-030 x0=0x7FFF, step=1, H_RES=4 -> re 7FFF,8000,8001,8002 (wrap).
REQ-031 start pulsed mid-frame with different x0 -> ignored, original sequence completes; start during done -> next frame starts at edge+1.
REQ-032 rst asserted after sample 5 -> all outputs 0 immediately (asynchronously), no done pulse; restart yields the full sequence from (x0,y0).
REQ-033 step=0, H_RES=4, V_RES=3 -> 12 samples all equal to (x0,y0); eol/last flags are unchanged from REQ-028.
